rr_mux4: RTL and testbench

- 4-to-1 round-robin stream multiplexer with a valid/ready handshake. It is the collecting end of the 1-to-4 demux path.
- Merges four independent input lanes into one registered output stream.
- Tags each output word with its source lane index so a downstream demux can route the word back out by `sel`.
- Sits upstream of the demux in the lane-routing datapath.

---
 rtl/rr_mux4.sv | 93 +++++++++
 tb/tb_rr_mux4.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// rr_mux4: 4-to-1 round-robin stream multiplexer with valid/ready handshake.
// Merges four input lanes into one registered output word, tagged with its
// source lane index so a downstream demux can route it back out by sel.
module rr_mux4 #(
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [3:0]      in_valid,
   input  logic [4*DW-1:0] in_data,
   output logic [3:0]      in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic [1:0]      out_sel
);

   logic            out_valid_q, out_valid_d;
   logic [DW-1:0]   out_data_q, out_data_d;
   logic [1:0]      out_sel_q, out_sel_d;
   logic [1:0]      last_q, last_d;

   logic [DW-1:0]   lane_data [4];
   logic [1:0]      grant;
   logic [1:0]      cand;
   logic            load;

   // Unpack the flat lane bus into per-lane words.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         lane_data[i] = in_data[i*DW +: DW];
      end
   end

   // Rotating priority search starting at last+1; the lowest offset with a
   // valid lane is written last and therefore wins.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      grant = last_q;
      cand  = last_q;
      for (int k = 3; k >= 0; k--) begin
         cand = last_q + 2'(k + 1);
         if (in_valid[cand]) begin
            grant = cand;
         end
      end
   end

   // Accept a word when enabled, some lane is valid and the output slot is
   // free or draining this cycle. Gated by rst_n so no ready escapes in reset.
   always_comb begin
      load     = rst_n & en & (|in_valid) & (~out_valid_q | out_ready);
      in_ready = load ? (4'b0001 << grant) : 4'b0000;
   end

   // Next-state for the output register and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      last_d      = last_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = lane_data[grant];
         out_sel_d   = grant;
         last_d      = grant;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; pointer resets to 3 so lane 0 is searched first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= 2'd0;
         last_q      <= 2'd3;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         last_q      <= last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Directed testbench for rr_mux4 with a protocol monitor and scoreboard.
module tb_rr_mux4;

   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            en = 1'b1;
   logic [3:0]      in_valid = 4'b0000;
   logic [4*DW-1:0] in_data = '0;
   logic [3:0]      in_ready;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_sel;

   int n_cmp = 0;
   int n_err = 0;

   logic [9:0] sb_q [$];

   rr_mux4 #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel)
   );

   always #5 clk = ~clk;

   // Protocol monitor and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      logic [9:0] exp_w;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         n_cmp++;
         if ($countones(in_ready) > 1) begin
            n_err++;
            $display("FAIL mon_onehot: in_ready=%b, required at most one bit", in_ready);
         end
         n_cmp++;
         if (out_valid && !out_ready && in_ready != 4'b0000) begin
            n_err++;
            $display("FAIL mon_stall: in_ready=%b during stall, required 0000", in_ready);
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL mon_unexpected: sel=%0d data=%h with no accepted word", out_sel, out_data);
            end else begin
               exp_w = sb_q.pop_front();
               if ({out_sel, out_data} !== exp_w) begin
                  n_err++;
                  $display("FAIL mon_order: sel/data=%h, required %h", {out_sel, out_data}, exp_w);
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && in_ready[i]) sb_q.push_back({2'(i), in_data[i*DW +: DW]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b1;
      en        = 1'b1;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 4'b1111;
      #1;
      n_cmp++;
      if ({out_valid, out_sel, out_data, in_ready} !== {1'b0, 2'd0, 8'h00, 4'b0000}) begin
         n_err++;
         $display("FAIL rst_state: v/sel/data/rdy=%b/%0d/%h/%b, required 0/0/00/0000",
                  out_valid, out_sel, out_data, in_ready);
      end
      tick();
      rst_n     = 1'b1;
      in_valid  = 4'b0101;
      in_data   = {8'h00, 8'h22, 8'h00, 8'h11};
      out_ready = 1'b0;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL rst_first_grant: in_ready=%b, required 0001", in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'h11}) begin
         n_err++;
         $display("FAIL rst_load0: v/sel/data=%b/%0d/%h, required 1/0/11", out_valid, out_sel, out_data);
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0100) begin
         n_err++;
         $display("FAIL rst_second_grant: in_ready=%b, required 0100", in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd2, 8'h22}) begin
         n_err++;
         $display("FAIL rst_load2: v/sel/data=%b/%0d/%h, required 1/2/22", out_valid, out_sel, out_data);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_sel, out_data, in_ready} !== {1'b0, 2'd0, 8'h00, 4'b0000}) begin
         n_err++;
         $display("FAIL rst_midstream: v/sel/data/rdy=%b/%0d/%h/%b, required 0/0/00/0000",
                  out_valid, out_sel, out_data, in_ready);
      end
      tick();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL rst_ptr_restored: in_ready=%b, required 0001", in_ready);
      end
   endtask

   task automatic test_rotation();
      logic [1:0] es;
      do_reset();
      in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         tick();
         es = 2'(k % 4);
         n_cmp++;
         if ({out_valid, out_sel, out_data} !== {1'b1, es, 8'hA0 + 8'(es)}) begin
            n_err++;
            $display("FAIL rot_%0d: v/sel/data=%b/%0d/%h, required 1/%0d/%h",
                     k, out_valid, out_sel, out_data, es, 8'hA0 + 8'(es));
         end
      end
   endtask

   task automatic test_sparse();
      logic [1:0] es;
      do_reset();
      in_data  = {8'hB3, 8'h00, 8'hB1, 8'h00};
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         es = (k % 2 == 0) ? 2'd1 : 2'd3;
         n_cmp++;
         if ({out_valid, out_sel, out_data} !== {1'b1, es, (es == 2'd1) ? 8'hB1 : 8'hB3}) begin
            n_err++;
            $display("FAIL sparse_%0d: v/sel/data=%b/%0d/%h, required 1/%0d/%h",
                     k, out_valid, out_sel, out_data, es, (es == 2'd1) ? 8'hB1 : 8'hB3);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      in_data   = {8'h00, 8'h55, 8'h00, 8'h00};
      in_valid  = 4'b0100;
      tick();
      in_data  = {8'h66, 8'h77, 8'h00, 8'h00};
      in_valid = 4'b1100;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if ({out_valid, out_sel, out_data, in_ready} !== {1'b1, 2'd2, 8'h55, 4'b0000}) begin
            n_err++;
            $display("FAIL bp_hold_%0d: v/sel/data/rdy=%b/%0d/%h/%b, required 1/2/55/0000",
                     k, out_valid, out_sel, out_data, in_ready);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL bp_release_grant: in_ready=%b, required 1000", in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd3, 8'h66}) begin
         n_err++;
         $display("FAIL bp_reload: v/sel/data=%b/%0d/%h, required 1/3/66", out_valid, out_sel, out_data);
      end
      in_valid = 4'b0000;
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b0, 2'd3, 8'h66}) begin
         n_err++;
         $display("FAIL bp_drain: v/sel/data=%b/%0d/%h, required 0/3/66", out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_enable();
      do_reset();
      out_ready = 1'b0;
      in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      in_valid  = 4'b1111;
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd0, 8'hC0}) begin
         n_err++;
         $display("FAIL en_load: v/sel/data=%b/%0d/%h, required 1/0/C0", out_valid, out_sel, out_data);
      end
      en        = 1'b0;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL en_gate: in_ready=%b, required 0000", in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data, in_ready} !== {1'b0, 2'd0, 8'hC0, 4'b0000}) begin
         n_err++;
         $display("FAIL en_drain: v/sel/data/rdy=%b/%0d/%h/%b, required 0/0/C0/0000",
                  out_valid, out_sel, out_data, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL en_idle: out_valid=%b, required 0", out_valid);
      end
      en = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0010) begin
         n_err++;
         $display("FAIL en_resume_grant: in_ready=%b, required 0010", in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 2'd1, 8'hC1}) begin
         n_err++;
         $display("FAIL en_resume: v/sel/data=%b/%0d/%h, required 1/1/C1", out_valid, out_sel, out_data);
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_sparse();
      test_backpressure();
      test_enable();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
